// File: rtl/system_acl_iface_pll_reset_seq.sv
// -----------------------------------------------------------------------------
// system_acl_iface_pll_reset_seq
//
// Reset/lock sequencer for the kernel-clock PLL. Runs on the free-running
// reference clock, pulses the PLL reset, qualifies the (asynchronous) lock
// indication and only then releases the kernel-domain reset request. A lock
// loss while running re-resets the PLL; lock timeouts are retried a bounded
// number of times before parking in a sticky failure state.
//
// Ports
//   clk            reference clock (same net as PLL refclk)
//   resetn         synchronous active-low reset
//   pll_locked     PLL lock output, asynchronous to clk
//   sw_reset_req   single-cycle host restart request (clk domain)
//   pll_rst        PLL reset, active-high
//   kernel_resetn  kernel reset request, active-low
//   retry_fail     sticky: retries exhausted
//   lock_lost_cnt  saturating count of lock losses seen while running
//   state          debug view of the FSM state
// -----------------------------------------------------------------------------
module system_acl_iface_pll_reset_seq #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       pll_rst,
    output logic       kernel_resetn,
    output logic       retry_fail,
    output logic [7:0] lock_lost_cnt,
    output logic [2:0] state
);

    // One shared counter sized for the longest interval it has to time.
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES
                                                                    : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT    = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RTY_W-1:0]       retry_q, retry_d;
    logic                   fail_q, fail_d;
    logic [7:0]             llc_q, llc_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pll_rst_q, kresetn_q;
    logic                   lk;

    assign lk = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        fail_d  = fail_q;
        llc_d   = llc_q;

        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RTY_LIMIT) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_PLL_RST;
                    end else begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STABLE: begin
                // A dropout during qualification restarts the wait without
                // consuming a retry.
                if (!lk) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            end
            S_FAIL: begin
                // Terminal until resetn or sw_reset_req.
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Lock loss is recorded even when a host request overrides the move.
        if ((state_q == S_RUN) && !lk && (llc_q != 8'hFF))
            llc_d = llc_q + 8'd1;

        // Host request beats every other transition.
        if (sw_reset_req) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
            fail_d  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State and registered outputs (decoded from next state so every output
    // moves on the same edge as the state)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q    <= '0;
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            fail_q    <= 1'b0;
            llc_q     <= '0;
            pll_rst_q <= 1'b1;
            kresetn_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            fail_q    <= fail_d;
            llc_q     <= llc_d;
            pll_rst_q <= (state_d == S_PLL_RST);
            kresetn_q <= (state_d == S_RUN);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign kernel_resetn = kresetn_q;
    assign retry_fail    = fail_q;
    assign lock_lost_cnt = llc_q;
    assign state         = state_q;

endmodule

// File: tb/tb_system_acl_iface_pll_reset_seq.sv
module tb_system_acl_iface_pll_reset_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       kernel_resetn;
    logic       retry_fail;
    logic [7:0] lock_lost_cnt;
    logic [2:0] state;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    system_acl_iface_pll_reset_seq #(
        .SYNC_STAGES        (2),
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .pll_rst      (pll_rst),
        .kernel_resetn(kernel_resetn),
        .retry_fail   (retry_fail),
        .lock_lost_cnt(lock_lost_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output snapshot, tagged with the cycle it applies to.
    typedef struct {
        int         at;
        string      nm;
        logic [2:0] st;
        logic       pr;
        logic       kr;
        logic       rf;
        logic [7:0] llc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    task automatic expect_at(input int at, input string nm, input logic [2:0] st,
                             input logic pr, input logic kr, input logic rf,
                             input logic [7:0] llc);
        exp_t e;
        e.at = at; e.nm = nm; e.st = st; e.pr = pr; e.kr = kr; e.rf = rf; e.llc = llc;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare outputs mid-cycle against any expectation due now.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            vectors++;
            if (cur.at < cyc) begin
                miscompares++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                         cur.nm, cur.at, cyc);
            end else if (state !== cur.st || pll_rst !== cur.pr || kernel_resetn !== cur.kr ||
                         retry_fail !== cur.rf || lock_lost_cnt !== cur.llc) begin
                miscompares++;
                $display("FAIL %s @%0d: got st=%0d prst=%b krn=%b rf=%b llc=%0d, want st=%0d prst=%b krn=%b rf=%b llc=%0d",
                         cur.nm, cyc, state, pll_rst, kernel_resetn, retry_fail, lock_lost_cnt,
                         cur.st, cur.pr, cur.kr, cur.rf, cur.llc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int b2;
        logic [7:0] ex;

        resetn = 1'b0; pll_locked = 1'b1; sw_reset_req = 1'b0;
        tick(3);
        expect_at(cyc, "reset", 0, 1, 0, 0, 0);

        // Clean bring-up, lock present from reset
        resetn = 1'b1; b = cyc;
        expect_at(b + 3,  "up_rst_hold", 0, 1, 0, 0, 0);
        expect_at(b + 4,  "up_wait",     1, 0, 0, 0, 0);
        expect_at(b + 5,  "up_stable",   2, 0, 0, 0, 0);
        expect_at(b + 12, "up_pre_run",  2, 0, 0, 0, 0);
        expect_at(b + 13, "up_run",      3, 0, 1, 0, 0);
        tick(14);

        // Restart via host, then a one-cycle lock glitch during qualification
        b = cyc; sw_reset_req = 1'b1;
        expect_at(b + 1,  "gl_sw",        0, 1, 0, 0, 0);
        expect_at(b + 5,  "gl_wait",      1, 0, 0, 0, 0);
        expect_at(b + 6,  "gl_stable",    2, 0, 0, 0, 0);
        expect_at(b + 10, "gl_pre_drop",  2, 0, 0, 0, 0);
        expect_at(b + 11, "gl_drop_wait", 1, 0, 0, 0, 0);
        expect_at(b + 12, "gl_restable",  2, 0, 0, 0, 0);
        expect_at(b + 19, "gl_pre_run",   2, 0, 0, 0, 0);
        expect_at(b + 20, "gl_run",       3, 0, 1, 0, 0);
        tick(1); sw_reset_req = 1'b0;
        tick(7); pll_locked = 1'b0;
        tick(1); pll_locked = 1'b1;
        tick(11);

        // Lock loss while running, 300 times (counter saturates at 255)
        for (int n = 1; n <= 300; n++) begin
            b  = cyc;
            ex = (n > 255) ? 8'd255 : 8'(n);
            pll_locked = 1'b0;
            if (n == 1) expect_at(b + 2, "loss_pre", 3, 0, 1, 0, 0);
            expect_at(b + 3, "loss_rst", 0, 1, 0, 0, ex);
            if (n == 1) begin
                expect_at(b + 6, "loss_rst_last", 0, 1, 0, 0, ex);
                expect_at(b + 7, "loss_wait",     1, 0, 0, 0, ex);
            end
            expect_at(b + 16, "loss_rerun", 3, 0, 1, 0, ex);
            tick(1); pll_locked = 1'b1;
            tick(15);
        end

        // Lock never returns: initial pulse plus two retries, then failure
        b = cyc; pll_locked = 1'b0;
        expect_at(b + 3,   "rt_p1",      0, 1, 0, 0, 255);
        expect_at(b + 7,   "rt_w1",      1, 0, 0, 0, 255);
        expect_at(b + 38,  "rt_w1_last", 1, 0, 0, 0, 255);
        expect_at(b + 39,  "rt_p2",      0, 1, 0, 0, 255);
        expect_at(b + 42,  "rt_p2_last", 0, 1, 0, 0, 255);
        expect_at(b + 43,  "rt_w2",      1, 0, 0, 0, 255);
        expect_at(b + 75,  "rt_p3",      0, 1, 0, 0, 255);
        expect_at(b + 79,  "rt_w3",      1, 0, 0, 0, 255);
        expect_at(b + 110, "rt_w3_last", 1, 0, 0, 0, 255);
        expect_at(b + 111, "rt_fail",    4, 0, 0, 1, 255);
        expect_at(b + 130, "rt_fail_hold", 4, 0, 0, 1, 255);
        tick(131);

        // Host recovery from failure
        b = cyc; pll_locked = 1'b1; sw_reset_req = 1'b1;
        expect_at(b + 1,  "hr_sw",      0, 1, 0, 0, 255);
        expect_at(b + 5,  "hr_wait",    1, 0, 0, 0, 255);
        expect_at(b + 6,  "hr_stable",  2, 0, 0, 0, 255);
        expect_at(b + 13, "hr_pre_run", 2, 0, 0, 0, 255);
        expect_at(b + 14, "hr_run",     3, 0, 1, 0, 255);
        tick(1); sw_reset_req = 1'b0;
        tick(13);

        // resetn asserted mid-qualification
        b = cyc; sw_reset_req = 1'b1;
        expect_at(b + 1, "mr_sw",     0, 1, 0, 0, 255);
        expect_at(b + 7, "mr_stable", 2, 0, 0, 0, 255);
        expect_at(b + 8, "mr_reset",  0, 1, 0, 0, 0);
        tick(1); sw_reset_req = 1'b0;
        tick(6); resetn = 1'b0;
        tick(2); resetn = 1'b1; b2 = cyc;
        expect_at(b2 + 4,  "mr_up_wait", 1, 0, 0, 0, 0);
        expect_at(b2 + 13, "mr_up_run",  3, 0, 1, 0, 0);
        tick(14);

        // Host request on the same edge the FSM sees lock loss
        b = cyc; pll_locked = 1'b0;
        expect_at(b + 2,  "sim_pre",   3, 0, 1, 0, 0);
        expect_at(b + 3,  "sim_sw",    0, 1, 0, 0, 1);
        expect_at(b + 7,  "sim_wait",  1, 0, 0, 0, 1);
        expect_at(b + 16, "sim_rerun", 3, 0, 1, 0, 1);
        tick(1); pll_locked = 1'b1;
        tick(1); sw_reset_req = 1'b1;
        tick(1); sw_reset_req = 1'b0;
        tick(13);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            miscompares += sb.size();
            $display("FAIL drain: %0d expectations never checked", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
